// File: rtl/sdram_fb_arbiter.sv
// Two-port arbiter in front of one Avalon-MM SDRAM controller: a high-priority
// read-only framebuffer port (A) and a read/write plotter port (B).
module sdram_fb_arbiter #(
  parameter int unsigned ADDR_W       = 25,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned MAX_PENDING  = 8,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic                           clk_clk,
  input  logic                           reset_reset,
  input  logic [ADDR_W-1:0]              a_address,
  input  logic                           a_read,
  output logic                           a_waitrequest,
  output logic [DATA_W-1:0]              a_readdata,
  output logic                           a_readdatavalid,
  input  logic [ADDR_W-1:0]              b_address,
  input  logic                           b_read,
  input  logic                           b_write,
  input  logic [DATA_W-1:0]              b_writedata,
  input  logic [1:0]                     b_byteenable,
  output logic                           b_waitrequest,
  output logic [DATA_W-1:0]              b_readdata,
  output logic                           b_readdatavalid,
  output logic [ADDR_W-1:0]              m_address,
  output logic                           m_read,
  output logic                           m_write,
  output logic [DATA_W-1:0]              m_writedata,
  output logic [1:0]                     m_byteenable,
  input  logic                           m_waitrequest,
  input  logic [DATA_W-1:0]              m_readdata,
  input  logic                           m_readdatavalid,
  output logic [$clog2(MAX_PENDING):0]   pending_count,
  output logic                           err_unexpected_rdv
);

  localparam int unsigned PTR_W = $clog2(MAX_PENDING);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);

  logic                   lock_q, lock_d;
  logic                   lock_b_q, lock_b_d;
  logic [SC_W-1:0]        starve_q, starve_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   err_q, err_d;
  logic [MAX_PENDING-1:0] tag_q, tag_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [1:0]             be_q, be_d;

  logic full, b_wr, b_rd, a_elig, b_elig;
  logic gnt, gnt_b, accept, push, pop;

  // Grant: a stalled command keeps the bus; a starved B beats A; else A first.
  always_comb begin
    full   = (count_q >= CNT_W'(MAX_PENDING));
    b_wr   = b_write;
    b_rd   = b_read && !b_write;
    a_elig = a_read && !full;
    b_elig = b_wr || (b_rd && !full);
    gnt    = 1'b0;
    gnt_b  = 1'b0;
    if (lock_q) begin
      gnt   = 1'b1;
      gnt_b = lock_b_q;
    end else if ((starve_q == SC_W'(STARVE_LIMIT)) && b_elig) begin
      gnt   = 1'b1;
      gnt_b = 1'b1;
    end else if (a_elig) begin
      gnt   = 1'b1;
    end else if (b_elig) begin
      gnt   = 1'b1;
      gnt_b = 1'b1;
    end
    accept = gnt && !m_waitrequest;
  end

  // Command mux, tag FIFO, response steering and next-state.
  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    starve_d = starve_q;
    err_d    = err_q;

    if (gnt) begin
      addr_d  = gnt_b ? b_address : a_address;
      wdata_d = gnt_b ? b_writedata : wdata_q;
      be_d    = gnt_b ? b_byteenable : 2'b11;
    end
    m_address     = addr_d;
    m_writedata   = wdata_d;
    m_byteenable  = be_d;
    m_read        = gnt && (gnt_b ? b_rd : 1'b1);
    m_write       = gnt && gnt_b && b_wr;
    a_waitrequest = !(gnt && !gnt_b && !m_waitrequest);
    b_waitrequest = !(gnt && gnt_b && !m_waitrequest);

    lock_d   = gnt && m_waitrequest;
    lock_b_d = lock_d ? gnt_b : lock_b_q;

    push = accept && m_read;
    pop  = m_readdatavalid && (count_q != '0);
    if (push) begin
      tag_d[wr_ptr_q] = gnt_b;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (m_readdatavalid && (count_q == '0)) err_d = 1'b1;

    a_readdatavalid = pop && !tag_q[rd_ptr_q];
    b_readdatavalid = pop && tag_q[rd_ptr_q];
    a_readdata      = m_readdata;
    b_readdata      = m_readdata;

    if (!(b_read || b_write) || (accept && gnt_b)) starve_d = '0;
    else if (starve_q != SC_W'(STARVE_LIMIT))      starve_d = starve_q + SC_W'(1);

    pending_count      = count_q;
    err_unexpected_rdv = err_q;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      lock_q   <= 1'b0;
      lock_b_q <= 1'b0;
      starve_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      lock_q   <= lock_d;
      lock_b_q <= lock_b_d;
      starve_q <= starve_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Payload and tag storage carry no reset: only valid under the pointers/grant.
  always_ff @(posedge clk_clk) begin
    tag_q   <= tag_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
  end

endmodule

// File: tb/tb_sdram_fb_arbiter.sv
// Directed bench for sdram_fb_arbiter: queue-based reference model checked every
// cycle, plus hand-computed literal expectations along the scenarios.
module tb_sdram_fb_arbiter;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;
  localparam int MAXP   = 8;
  localparam int LIM    = 16;

  logic              clk = 1'b0;
  logic              reset_reset;
  logic [ADDR_W-1:0] a_address, b_address;
  logic              a_read, b_read, b_write;
  logic [DATA_W-1:0] b_writedata;
  logic [1:0]        b_byteenable;
  logic              a_waitrequest, a_readdatavalid, b_waitrequest, b_readdatavalid;
  logic [DATA_W-1:0] a_readdata, b_readdata;
  logic [ADDR_W-1:0] m_address;
  logic              m_read, m_write;
  logic [DATA_W-1:0] m_writedata;
  logic [1:0]        m_byteenable;
  logic              m_waitrequest, m_readdatavalid;
  logic [DATA_W-1:0] m_readdata;
  logic [3:0]        pending_count;
  logic              err_unexpected_rdv;

  sdram_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAXP),
                     .STARVE_LIMIT(LIM)) dut (
    .clk_clk(clk), .reset_reset(reset_reset),
    .a_address(a_address), .a_read(a_read), .a_waitrequest(a_waitrequest),
    .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
    .b_address(b_address), .b_read(b_read), .b_write(b_write),
    .b_writedata(b_writedata), .b_byteenable(b_byteenable),
    .b_waitrequest(b_waitrequest), .b_readdata(b_readdata),
    .b_readdatavalid(b_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .pending_count(pending_count), .err_unexpected_rdv(err_unexpected_rdv)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending reads as a queue of owners (0=A, 1=B).
  int q_tag[$];
  int starve = 0;
  bit err_m = 1'b0;
  bit lk = 1'b0;
  int lk_own = 0;
  int g;
  bit full_m, bw, br, ael, bel, acc, e_rd, e_wr, e_ardv, e_brdv;

  always @(negedge clk) begin
    if (chk_en) begin
      full_m = (q_tag.size() >= MAXP);
      bw  = b_write;
      br  = b_read && !b_write;
      ael = a_read && !full_m;
      bel = bw || (br && !full_m);
      if (lk)                      g = lk_own;
      else if (starve == LIM && bel) g = 2;
      else if (ael)                g = 1;
      else if (bel)                g = 2;
      else                         g = 0;
      e_rd   = (g == 1) || (g == 2 && br);
      e_wr   = (g == 2) && bw;
      e_ardv = m_readdatavalid && q_tag.size() > 0 && q_tag[0] == 0;
      e_brdv = m_readdatavalid && q_tag.size() > 0 && q_tag[0] == 1;
      chk("m_read", 32'(m_read), 32'(e_rd));
      chk("m_write", 32'(m_write), 32'(e_wr));
      chk("a_wait", 32'(a_waitrequest), 32'(!(g == 1 && !m_waitrequest)));
      chk("b_wait", 32'(b_waitrequest), 32'(!(g == 2 && !m_waitrequest)));
      chk("a_rdv", 32'(a_readdatavalid), 32'(e_ardv));
      chk("b_rdv", 32'(b_readdatavalid), 32'(e_brdv));
      chk("pending", 32'(pending_count), 32'(q_tag.size()));
      chk("err", 32'(err_unexpected_rdv), 32'(err_m));
      if (e_rd || e_wr) begin
        chk("m_addr", 32'(m_address), 32'(g == 1 ? a_address : b_address));
        chk("m_be", 32'(m_byteenable), 32'(g == 1 ? 2'b11 : b_byteenable));
      end
      if (e_wr) chk("m_wdata", 32'(m_writedata), 32'(b_writedata));
      if (e_ardv) chk("a_data", 32'(a_readdata), 32'(m_readdata));
      if (e_brdv) chk("b_data", 32'(b_readdata), 32'(m_readdata));

      if (reset_reset) begin
        q_tag.delete();
        starve = 0;
        err_m  = 1'b0;
        lk     = 1'b0;
      end else begin
        acc = (g != 0) && !m_waitrequest;
        if (m_readdatavalid) begin
          if (q_tag.size() > 0) void'(q_tag.pop_front());
          else err_m = 1'b1;
        end
        if (acc && e_rd) q_tag.push_back(g == 2 ? 1 : 0);
        lk     = (g != 0) && m_waitrequest;
        lk_own = g;
        if (!(b_read || b_write) || (acc && g == 2)) starve = 0;
        else if (starve < LIM) starve++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    a_read = 0; a_address = '0;
    b_read = 0; b_write = 0; b_address = '0; b_writedata = '0; b_byteenable = 2'b11;
    m_waitrequest = 0; m_readdatavalid = 0; m_readdata = '0;
  endtask

  initial begin
    idle();
    reset_reset = 1;
    repeat (2) @(posedge clk);
    #1 reset_reset = 0;
    chk_en = 1;
    at_neg();
    chk("rst_pending", 32'(pending_count), 32'd0);
    chk("rst_err", 32'(err_unexpected_rdv), 32'd0);
    chk("rst_mread", 32'(m_read), 32'd0);
    chk("rst_mwrite", 32'(m_write), 32'd0);
    chk("rst_await", 32'(a_waitrequest), 32'd1);
    chk("rst_bwait", 32'(b_waitrequest), 32'd1);
    step();

    // Single A read, response three cycles later.
    a_read = 1; a_address = 25'h100;
    at_neg();
    chk("t1_mread", 32'(m_read), 32'd1);
    chk("t1_addr", 32'(m_address), 32'h100);
    chk("t1_await", 32'(a_waitrequest), 32'd0);
    step(); a_read = 0;
    at_neg(); chk("t1_pend1", 32'(pending_count), 32'd1);
    step(); step();
    m_readdatavalid = 1; m_readdata = 16'hBEEF;
    at_neg();
    chk("t1_ardv", 32'(a_readdatavalid), 32'd1);
    chk("t1_adata", 32'(a_readdata), 32'hBEEF);
    chk("t1_brdv", 32'(b_readdatavalid), 32'd0);
    step(); m_readdatavalid = 0;
    at_neg(); chk("t1_pend0", 32'(pending_count), 32'd0);
    step();

    // Starvation: A reads every cycle, B write waits 16 cycles then wins once.
    a_read = 1; a_address = 25'h140;
    b_write = 1; b_address = 25'h200; b_writedata = 16'h1234; b_byteenable = 2'b11;
    for (int k = 0; k <= 16; k++) begin
      m_readdatavalid = (k >= 1); m_readdata = 16'(k);
      at_neg();
      if (k < 16) begin
        chk("t2_bwait", 32'(b_waitrequest), 32'd1);
        chk("t2_aread", 32'(m_read), 32'd1);
      end else begin
        chk("t2_bwrite", 32'(m_write), 32'd1);
        chk("t2_baddr", 32'(m_address), 32'h200);
        chk("t2_bdata", 32'(m_writedata), 32'h1234);
        chk("t2_bgo", 32'(b_waitrequest), 32'd0);
      end
      step();
    end
    b_write = 0; m_readdatavalid = 0;
    at_neg();
    chk("t2_aresume", 32'(m_read), 32'd1);
    chk("t2_ago", 32'(a_waitrequest), 32'd0);
    step(); a_read = 0; m_readdatavalid = 1; m_readdata = 16'h0A0A;
    at_neg(); chk("t2_ardv", 32'(a_readdatavalid), 32'd1);
    step(); m_readdatavalid = 0;
    step();

    // B write stalled five cycles while A rises; A follows after acceptance.
    b_write = 1; b_address = 25'h300; b_writedata = 16'h5A5A; b_byteenable = 2'b01;
    m_waitrequest = 1;
    for (int k = 0; k < 5; k++) begin
      if (k >= 1) begin a_read = 1; a_address = 25'h400; end
      at_neg();
      chk("t3_mwrite", 32'(m_write), 32'd1);
      chk("t3_addr", 32'(m_address), 32'h300);
      chk("t3_await", 32'(a_waitrequest), 32'd1);
      step();
    end
    m_waitrequest = 0;
    at_neg();
    chk("t3_bacc", 32'(b_waitrequest), 32'd0);
    chk("t3_be", 32'(m_byteenable), 32'h1);
    step(); b_write = 0;
    at_neg();
    chk("t3_aread", 32'(m_read), 32'd1);
    chk("t3_aaddr", 32'(m_address), 32'h400);
    chk("t3_ago", 32'(a_waitrequest), 32'd0);
    step(); a_read = 0; m_readdatavalid = 1; m_readdata = 16'h7777;
    step(); m_readdatavalid = 0;
    step();

    // Fill the tag FIFO with A,B,A,B...; 9th read blocks, B write still goes.
    for (int i = 0; i < 8; i++) begin
      a_read = (i % 2 == 0); a_address = 25'(32'h500 + i);
      b_read = (i % 2 == 1); b_address = 25'(32'h600 + i);
      step();
    end
    b_read = 0;
    a_read = 1; a_address = 25'h700;
    b_write = 1; b_address = 25'h800; b_writedata = 16'hCAFE; b_byteenable = 2'b10;
    at_neg();
    chk("t4_full", 32'(pending_count), 32'd8);
    chk("t4_wr", 32'(m_write), 32'd1);
    chk("t4_rd", 32'(m_read), 32'd0);
    chk("t4_ablk", 32'(a_waitrequest), 32'd1);
    chk("t4_bgo", 32'(b_waitrequest), 32'd0);
    step(); b_write = 0;
    at_neg();
    chk("t4_stall", 32'(m_read), 32'd0);
    chk("t4_ablk2", 32'(a_waitrequest), 32'd1);
    step();
    for (int r = 0; r < 8; r++) begin
      m_readdatavalid = 1; m_readdata = 16'(32'hD000 + r);
      if (r == 2) a_read = 0;
      at_neg();
      chk("t4_route_a", 32'(a_readdatavalid), 32'(r % 2 == 0));
      chk("t4_route_b", 32'(b_readdatavalid), 32'(r % 2 == 1));
      step();
    end
    m_readdatavalid = 1; m_readdata = 16'hE000;
    at_neg(); chk("t4_ninth", 32'(a_readdatavalid), 32'd1);
    step(); m_readdatavalid = 0;
    at_neg(); chk("t4_empty", 32'(pending_count), 32'd0);
    step();

    // Unexpected response with nothing pending.
    m_readdatavalid = 1; m_readdata = 16'h1111;
    at_neg();
    chk("t5_ardv", 32'(a_readdatavalid), 32'd0);
    chk("t5_brdv", 32'(b_readdatavalid), 32'd0);
    step(); m_readdatavalid = 0;
    at_neg();
    chk("t5_err", 32'(err_unexpected_rdv), 32'd1);
    chk("t5_pend", 32'(pending_count), 32'd0);
    repeat (3) step();
    at_neg(); chk("t5_sticky", 32'(err_unexpected_rdv), 32'd1);
    step();

    // Reset with three reads pending and a stalled B write.
    for (int i = 0; i < 3; i++) begin
      a_read = 1; a_address = 25'(32'h900 + i);
      step();
    end
    a_read = 0;
    b_write = 1; b_address = 25'hA00; b_writedata = 16'h4242; m_waitrequest = 1;
    at_neg();
    chk("t6_stall", 32'(m_write), 32'd1);
    chk("t6_bwait", 32'(b_waitrequest), 32'd1);
    step(); reset_reset = 1;
    step(); reset_reset = 0; b_write = 0;
    at_neg();
    chk("t6_pend", 32'(pending_count), 32'd0);
    chk("t6_mread", 32'(m_read), 32'd0);
    chk("t6_mwrite", 32'(m_write), 32'd0);
    chk("t6_err", 32'(err_unexpected_rdv), 32'd0);
    step(); m_waitrequest = 0; a_read = 1; a_address = 25'hB00;
    at_neg();
    chk("t6_unlock", 32'(m_read), 32'd1);
    chk("t6_uaddr", 32'(m_address), 32'hB00);
    step(); a_read = 0; m_readdatavalid = 1;
    at_neg(); chk("t6_own", 32'(a_readdatavalid), 32'd1);
    step();
    at_neg(); chk("t6_stale", 32'(err_unexpected_rdv), 32'd0);
    step(); m_readdatavalid = 0;
    at_neg(); chk("t6_stale_err", 32'(err_unexpected_rdv), 32'd1);
    step();
    idle();
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
